// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : encoding of ADDI x0,x0,0, used as the bubble instruction
//   fetch_state_t : fetch sequencer states
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response channel.
//   imem_req   : fetch request (master -> memory)
//   imem_addr  : word-aligned fetch address (master -> memory)
//   imem_rdata : returned instruction, valid when imem_ready=1 (memory -> master)
//   imem_ready : memory completes the current request this cycle (memory -> master)
interface instruction_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n         : clock, async active-low reset (resets to a bubble)
//   load               : capture pc_in / instr_in as a valid instruction
//   hold               : keep current contents
//   flush              : replace contents with a bubble (wins over hold and load)
//   pc_in, instr_in    : fetched PC and instruction
//   pc, instr, valid   : registered IF/ID contents
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  // Priority: flush > hold > load; otherwise contents are retained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (hold) begin
      pc    <= pc;
      instr <= instr;
      valid <= valid;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues instruction-memory requests and
// loads the IF/ID register, inserting bubbles for memory wait states and
// redirects.
//   RESET_PC          : first PC fetched after reset
//   clk, rst_n        : clock, async active-low reset
//   PCWrite           : 0 = hold PC (hazard unit)
//   IF_IDWrite        : 0 = hold IF/ID (hazard unit)
//   ID_branch_taken   : redirect resolved in ID
//   ID_branch_target  : redirect address, low two bits ignored
//   imem              : instruction-memory channel (master side)
//   IF_ID_pc/instr/valid : registered IF/ID contents
//   fetch_stall       : request outstanding and memory not ready
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PCWrite,
  input  logic                     IF_IDWrite,
  input  logic                     ID_branch_taken,
  input  logic [XLEN-1:0]          ID_branch_target,
  instruction_fetch_unit_if.master imem,
  output logic [XLEN-1:0]          IF_ID_pc,
  output logic [XLEN-1:0]          IF_ID_instr,
  output logic                     IF_ID_valid,
  output logic                     fetch_stall
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] save_target, save_target_nxt;
  logic            stall, redir;
  logic [XLEN-1:0] target;
  logic            ifid_load, ifid_hold, ifid_flush;

  assign stall  = !PCWrite || !IF_IDWrite;
  // An instruction stalled in ID is not yet resolved, so its redirect is ignored.
  assign redir  = ID_branch_taken && !stall;
  assign target = ID_branch_target & ALIGN_MASK;

  // State, PC and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC & ALIGN_MASK;
      save_target <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      save_target <= save_target_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    save_target_nxt = save_target;
    ifid_load       = 1'b0;
    ifid_hold       = 1'b0;
    ifid_flush      = 1'b0;
    imem.imem_req   = 1'b0;

    unique case (state)
      IDLE: begin
        pc_nxt     = RESET_PC & ALIGN_MASK;
        ifid_flush = 1'b1;
        state_nxt  = REQ;
      end

      REQ: begin
        imem.imem_req = 1'b1;
        if (redir) begin
          ifid_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_nxt = target;
          end else begin
            // Request is in flight on the old PC; finish it before redirecting.
            save_target_nxt = target;
            state_nxt       = DISCARD;
          end
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else if (imem.imem_ready) begin
          ifid_load = 1'b1;
          pc_nxt    = pc + XLEN'(4);
        end else begin
          ifid_flush = 1'b1;
        end
      end

      DISCARD: begin
        imem.imem_req = 1'b1;
        if (redir) begin
          save_target_nxt = target;
        end
        if (imem.imem_ready) begin
          // A redirect arriving in the same cycle is the newest one.
          pc_nxt    = redir ? target : save_target;
          state_nxt = REQ;
        end
        if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end

      default: begin
        state_nxt  = IDLE;
        ifid_flush = 1'b1;
      end
    endcase
  end

  assign imem.imem_addr = pc;
  assign fetch_stall    = imem.imem_req && !imem.imem_ready;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .hold     (ifid_hold),
    .flush    (ifid_flush),
    .pc_in    (pc),
    .instr_in (imem.imem_rdata),
    .pc       (IF_ID_pc),
    .instr    (IF_ID_instr),
    .valid    (IF_ID_valid)
  );

endmodule
